// File: rtl/demodulation_segment_collector_pkg.sv
// Shared constants and launch-state encoding for the demodulation segment collector.
package demodulation_segment_collector_pkg;
  localparam int DATA_W    = 32;
  localparam int SEG_COUNT = 10;
  localparam int IDX_W     = 4;

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_RUN  = 2'd1,
    L_GAP  = 2'd2
  } launch_state_t;
endpackage

// File: rtl/demodulation_frame_bank.sv
// One frame bank: SEG_COUNT sample registers written by index, plus a full flag.
module demodulation_frame_bank #(
  parameter int DATA_W = demodulation_segment_collector_pkg::DATA_W
) (
  input  logic                                                             clk,
  input  logic                                                             reset,
  input  logic                                                             wr_en,
  input  logic [demodulation_segment_collector_pkg::IDX_W-1:0]             wr_idx,
  input  logic [DATA_W-1:0]                                                wr_data,
  input  logic                                                             set_full,
  input  logic                                                             clr_full,
  output logic [demodulation_segment_collector_pkg::SEG_COUNT-1:0][DATA_W-1:0] seg_data,
  output logic                                                             full
);
  import demodulation_segment_collector_pkg::*;

  logic [DATA_W-1:0] mem_reg [SEG_COUNT];
  logic              full_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SEG_COUNT; i++) mem_reg[i] <= '0;
      full_reg <= 1'b0;
    end else begin
      for (int i = 0; i < SEG_COUNT; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) mem_reg[i] <= wr_data;
      end
      // set and clear never target the same bank on one edge; set wins defensively
      if (set_full)      full_reg <= 1'b1;
      else if (clr_full) full_reg <= 1'b0;
    end
  end

  for (genvar gi = 0; gi < SEG_COUNT; gi++) begin : g_out
    assign seg_data[gi] = mem_reg[gi];
  end

  assign full = full_reg;
endmodule

// File: rtl/demodulation_segment_collector.sv
// Double-buffered collector: serial samples fill one bank while the other is held for the demodulator.
module demodulation_segment_collector #(
  parameter int DATA_W    = demodulation_segment_collector_pkg::DATA_W,
  parameter int SEG_COUNT = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic [DATA_W-1:0] segment_0,
  output logic [DATA_W-1:0] segment_1,
  output logic [DATA_W-1:0] segment_2,
  output logic [DATA_W-1:0] segment_3,
  output logic [DATA_W-1:0] segment_4,
  output logic [DATA_W-1:0] segment_5,
  output logic [DATA_W-1:0] segment_6,
  output logic [DATA_W-1:0] segment_7,
  output logic [DATA_W-1:0] segment_8,
  output logic [DATA_W-1:0] segment_9,
  output logic              start,
  input  logic              done_in,
  output logic              frame_done,
  output logic              frames_dropped
);
  import demodulation_segment_collector_pkg::*;

  logic [9:0][DATA_W-1:0] bank_data [2];
  logic [9:0][DATA_W-1:0] seg_sel;
  logic [1:0]             bank_full;

  logic             fill_bank_reg;
  logic [IDX_W-1:0] fill_idx_reg;
  logic             launch_bank_reg;
  launch_state_t    state_reg;
  logic             start_reg;
  logic             frame_done_reg;

  logic xfer;
  logic last_write;
  logic retire;

  assign sample_ready = !bank_full[fill_bank_reg];
  assign xfer         = sample_valid && sample_ready;
  assign last_write   = (fill_idx_reg == IDX_W'(SEG_COUNT - 1));
  assign retire       = (state_reg == L_RUN) && done_in;

  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    demodulation_frame_bank #(.DATA_W(DATA_W)) u_bank (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (xfer && (fill_bank_reg == 1'(gi))),
      .wr_idx   (fill_idx_reg),
      .wr_data  (sample_in),
      .set_full (xfer && last_write && (fill_bank_reg == 1'(gi))),
      .clr_full (retire && (launch_bank_reg == 1'(gi))),
      .seg_data (bank_data[gi]),
      .full     (bank_full[gi])
    );
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fill_bank_reg <= 1'b0;
      fill_idx_reg  <= '0;
    end else if (xfer) begin
      if (last_write) begin
        fill_idx_reg  <= '0;
        fill_bank_reg <= ~fill_bank_reg;
      end else begin
        fill_idx_reg  <= fill_idx_reg + 1'b1;
      end
    end
  end

  // L_GAP forces start low for a cycle so the downstream can clear before the next frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg       <= L_IDLE;
      start_reg       <= 1'b0;
      frame_done_reg  <= 1'b0;
      launch_bank_reg <= 1'b0;
    end else begin
      frame_done_reg <= 1'b0;
      case (state_reg)
        L_IDLE: begin
          if (bank_full[launch_bank_reg]) begin
            state_reg <= L_RUN;
            start_reg <= 1'b1;
          end
        end
        L_RUN: begin
          if (done_in) begin
            state_reg       <= L_GAP;
            start_reg       <= 1'b0;
            frame_done_reg  <= 1'b1;
            launch_bank_reg <= ~launch_bank_reg;
          end
        end
        L_GAP: begin
          state_reg <= L_IDLE;
        end
        default: begin
          state_reg <= L_IDLE;
          start_reg <= 1'b0;
        end
      endcase
    end
  end

  assign seg_sel        = bank_data[launch_bank_reg];
  assign segment_0      = seg_sel[0];
  assign segment_1      = seg_sel[1];
  assign segment_2      = seg_sel[2];
  assign segment_3      = seg_sel[3];
  assign segment_4      = seg_sel[4];
  assign segment_5      = seg_sel[5];
  assign segment_6      = seg_sel[6];
  assign segment_7      = seg_sel[7];
  assign segment_8      = seg_sel[8];
  assign segment_9      = seg_sel[9];
  assign start          = start_reg;
  assign frame_done     = frame_done_reg;
  assign frames_dropped = 1'b0;
endmodule

// File: tb/tb_demodulation_segment_collector.sv
// Directed bench for the segment collector, finishing with a random-gap soak against a sample queue.
module tb_demodulation_segment_collector;
  logic        clk;
  logic        reset;
  logic [31:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [31:0] seg0, seg1, seg2, seg3, seg4, seg5, seg6, seg7, seg8, seg9;
  logic        start;
  logic        done_in;
  logic        frame_done;
  logic        frames_dropped;
  logic [31:0] seg [10];

  int n_cmp = 0;
  int n_err = 0;

  demodulation_segment_collector #(.DATA_W(32), .SEG_COUNT(10)) dut (
    .clk            (clk),
    .reset          (reset),
    .sample_in      (sample_in),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .segment_0      (seg0),
    .segment_1      (seg1),
    .segment_2      (seg2),
    .segment_3      (seg3),
    .segment_4      (seg4),
    .segment_5      (seg5),
    .segment_6      (seg6),
    .segment_7      (seg7),
    .segment_8      (seg8),
    .segment_9      (seg9),
    .start          (start),
    .done_in        (done_in),
    .frame_done     (frame_done),
    .frames_dropped (frames_dropped)
  );

  assign seg[0] = seg0; assign seg[1] = seg1; assign seg[2] = seg2; assign seg[3] = seg3;
  assign seg[4] = seg4; assign seg[5] = seg5; assign seg[6] = seg6; assign seg[7] = seg7;
  assign seg[8] = seg8; assign seg[9] = seg9;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    int q[$];
    int fd_cnt, frames, cyc, run_cnt, dly, next_val;
    bit checked;
    logic [31:0] exp;

    reset = 1'b0; sample_valid = 1'b0; sample_in = '0; done_in = 1'b0;
    repeat (3) tick();
    check("rst_start", start, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_seg0", seg0, 0);
    check("rst_seg9", seg9, 0);
    check("rst_dropped", frames_dropped, 0);
    reset = 1'b1;
    check("rst_ready", sample_ready, 1);

    // frame 1..10 into bank 0
    for (int i = 1; i <= 10; i++) begin
      sample_in = i; sample_valid = 1'b1;
      check("fill0_ready", sample_ready, 1);
      tick();
    end
    sample_in = 11;
    check("start_not_yet", start, 0);
    check("f1_seg0", seg0, 1);
    check("f1_seg9", seg9, 10);
    check("bank1_ready", sample_ready, 1);
    tick();
    check("start_rise", start, 1);

    // bank 1 fills with 11..20 while frame 1 runs
    for (int i = 12; i <= 20; i++) begin
      sample_in = i;
      check("fill1_ready", sample_ready, 1);
      tick();
    end
    sample_in = 21;
    check("both_full_ready", sample_ready, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_ready", sample_ready, 0);
      check("stall_start", start, 1);
      check("stall_seg0", seg0, 1);
      check("stall_seg9", seg9, 10);
    end

    done_in = 1'b1;
    tick();
    check("retire1_fd", frame_done, 1);
    check("retire1_start", start, 0);
    check("retire1_ready", sample_ready, 1);
    check("retire1_seg0", seg0, 11);
    done_in = 1'b0;
    tick();
    check("gap_fd", frame_done, 0);
    check("gap_start", start, 0);

    // samples 22..29, then sample 30 lands on the same edge frame 2 retires
    for (int i = 22; i <= 29; i++) begin
      sample_in = i;
      tick();
    end
    check("f2_start", start, 1);
    check("f2_seg0", seg0, 11);
    check("f2_seg9", seg9, 20);
    sample_in = 30; done_in = 1'b1;
    tick();
    check("coinc_fd", frame_done, 1);
    check("coinc_start", start, 0);
    check("coinc_ready", sample_ready, 1);
    sample_valid = 1'b0; done_in = 1'b0;
    tick();
    check("coinc_gap_fd", frame_done, 0);
    check("coinc_gap_start", start, 0);
    tick();
    check("f3_start", start, 1);
    check("f3_seg0", seg0, 21);
    check("f3_seg5", seg5, 26);
    check("f3_seg9", seg9, 30);

    // reset mid-frame with start high and a partial bank
    for (int i = 31; i <= 35; i++) begin
      sample_in = i; sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("pre_rst_start", start, 1);
    reset = 1'b0;
    #1;
    check("async_rst_start", start, 0);
    check("async_rst_seg0", seg0, 0);
    check("async_rst_seg9", seg9, 0);
    check("async_rst_fd", frame_done, 0);
    tick(); tick();
    reset = 1'b1;
    check("post_rst_ready", sample_ready, 1);
    check("post_rst_start", start, 0);
    for (int i = 50; i <= 59; i++) begin
      sample_in = i; sample_valid = 1'b1;
      check("post_rst_fill_ready", sample_ready, 1);
      tick();
    end
    sample_valid = 1'b0;
    check("post_rst_no_fd", frame_done, 0);
    check("post_rst_start_low", start, 0);
    tick();
    check("post_rst_start_rise", start, 1);
    for (int k = 0; k < 10; k++) check("post_rst_seg", seg[k], 50 + k);
    done_in = 1'b1;
    tick();
    check("post_rst_retire_fd", frame_done, 1);
    done_in = 1'b0;
    tick();
    check("post_rst_fd_pulse", frame_done, 0);

    // random-gap soak: 100 frames against a reference queue
    fd_cnt = 0; frames = 0; cyc = 0; run_cnt = 0; dly = 2; next_val = 100; checked = 1'b0;
    while (fd_cnt < 100 && cyc < 20000) begin
      if (frame_done) fd_cnt++;
      if (start) begin
        if (!checked) begin
          checked = 1'b1; run_cnt = 0; dly = $urandom_range(2, 6);
          check("soak_depth_ok", 32'(q.size() >= 10), 1);
          for (int k = 0; k < 10; k++) begin
            exp = (q.size() > 0) ? 32'(q.pop_front()) : 'x;
            check("soak_seg", seg[k], exp);
          end
          frames++;
        end
        run_cnt++;
        done_in = (run_cnt >= dly);
      end else begin
        checked = 1'b0;
        done_in = 1'b0;
      end
      sample_valid = (next_val < 1100) && ($urandom_range(0, 3) != 0);
      sample_in = next_val;
      if (sample_valid && sample_ready) begin
        q.push_back(next_val);
        next_val++;
      end
      tick();
      cyc++;
    end
    sample_valid = 1'b0; done_in = 1'b0;
    check("soak_frames_retired", fd_cnt, 100);
    check("soak_frames_checked", frames, 100);
    check("soak_queue_empty", q.size(), 0);
    check("soak_dropped", frames_dropped, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/demodulation_segment_collector.md
DEMODULATION_SEGMENT_COLLECTOR -- requirements
Module: demodulation_segment_collector

Interface
REQ-001 Parameter DATA_W, default 32: width of one sample and one segment.
REQ-002 Parameter SEG_COUNT, fixed 10: samples per frame; the implementation SHALL support only 10.
REQ-003 clk  input  1: single clock; all state changes on its rising edge.
REQ-004 reset  input  1: asynchronous, active-low reset (reset==0 resets).
REQ-005 sample_in  input  DATA_W: serial sample stream.
REQ-006 sample_valid  input  1: sample_in holds a valid sample.
REQ-007 sample_ready  output  1: collector can accept a sample; a transfer occurs when sample_valid && sample_ready.
REQ-008 segment_0 .. segment_9  output  DATA_W each: the frame presented to the downstream demodulator.
REQ-009 start  output  1: level request to the downstream demodulator, held while the frame is processed.
REQ-010 done_in  input  1: downstream completion level, high when its result is ready.
REQ-011 frame_done  output  1: one-cycle pulse when a frame is retired.
REQ-012 frames_dropped  output  1: always 0; reserved, because backpressure prevents loss.

Function
REQ-013 The block SHALL have two frame banks (0, 1), each with 10 DATA_W registers and a full flag.
- Fill pointer: fill_bank (1 bit), fill_idx (0..9).
- Launch pointer: launch_bank (1 bit).
REQ-014 On each transfer, sample_in SHALL be written to fill_bank[fill_idx], and fill_idx SHALL increment.
- When the write is at fill_idx==9: set full[fill_bank], fill_idx->0, toggle fill_bank.
REQ-015 sample_ready SHALL equal !full[fill_bank], so writes to a full bank are impossible.
REQ-016 Samples SHALL map in arrival order: the first sample of a frame to segment_0, the tenth to segment_9.
REQ-017 The launch FSM SHALL have three states, L_IDLE, L_RUN and L_GAP, with these transitions:
- L_IDLE -> L_RUN when full[launch_bank].
- L_RUN -> L_GAP when done_in==1.
- L_GAP -> L_IDLE unconditionally.
REQ-018 start SHALL be 1 only in L_RUN; L_GAP guarantees at least one start-low cycle so the downstream counter clears.
REQ-019 segment_k SHALL equal bank[launch_bank][k], and SHALL be stable for the whole of L_RUN.
REQ-020 On the L_RUN->L_GAP transition, the block SHALL:
- clear full[launch_bank];
- toggle launch_bank;
- pulse frame_done for exactly that cycle.
REQ-021 Latency: start SHALL rise on the first edge after the tenth transfer, provided the FSM is in L_IDLE.
REQ-022 If a bank completes filling and the other bank is freed on the same edge, both updates SHALL take effect; neither is lost.
REQ-023 While one bank is in L_RUN, the other bank SHALL accept samples; with both banks full, sample_ready SHALL be 0 until frame_done.
REQ-024 done_in SHALL be ignored in L_IDLE and L_GAP.
REQ-025 A done_in pulse that is still high on the first L_RUN cycle SHALL retire the frame; the downstream guarantees done_in==0 on the cycle after start rises.
REQ-026 Throughput: one frame per 10 sample cycles, or per downstream time + 2 cycles, whichever is slower.

Reset
REQ-027 Asserting reset SHALL immediately set the following, regardless of the current state:
- FSM to L_IDLE;
- start=0, frame_done=0;
- full flags 0; fill_bank=0, fill_idx=0, launch_bank=0;
- sample_ready=1 once reset is released.
REQ-028 Bank data registers SHALL reset to 0, so segment_0..9 read 0 after reset.
REQ-029 A reset asserted mid-frame SHALL discard both partial and full frames; no frame_done SHALL be issued for them.

Structure
REQ-030 A shared package SHALL hold DATA_W, SEG_COUNT and the launch-state enumeration (L_IDLE, L_RUN, L_GAP).
REQ-031 One sub-module, demodulation_frame_bank, SHALL be instantiated twice.
- Holds the 10 registers with write-enable and index.
- Holds the full flag with set and clear inputs.
- The FSM and pointers SHALL live in the top level.

Verification
REQ-032 Reset, then stream 1..10 with valid held high -> segment_0=1 … segment_9=10; start=1 on the cycle after sample 10; sample_ready stays 1.
REQ-033 Hold done_in=0 and stream 11..30 -> bank 1 fills with 11..20; sample_ready=0 after sample 20; samples 21..30 stall; segments stay 1..10.
REQ-034 Raise done_in 14 cycles after start, drop it when start falls:
- frame_done pulses once, with start low for ≥1 cycle;
- then start rises with segments 11..20;
- sample_ready returns to 1.
REQ-035 Deliver the tenth sample of a frame on the same edge that done_in retires the other frame -> both banks update; the next start launches the new frame with no sample lost.
REQ-036 Pull reset low after 5 samples with start high -> start=0 and segments=0 immediately; after release, samples 50..59 appear as segment_0..9.
REQ-037 Drive random gaps on sample_valid over 100 frames -> every frame matches a reference queue; frames_dropped stays 0.
